conv_result_serializer: RTL and testbench
=========================================

# conv_result_serializer

- Downstream of the 4×4 linear-convolution stage, which produces seven parallel result words y1..y7 in one cycle.
- Captures one such result frame and streams the words out one per cycle, y1 first.
- Uses a valid/ready handshake on both sides.
- Lets the combinational convolution stage feed narrow sequential consumers such as a FIFO, UART framer or accumulator.

## Interface
- Y_W, default 8: width of one convolution result word.
- N_OUT, default 7: words per frame (y1..yN_OUT).
- CNT_W, default 8: width of the frame counter.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  a result frame is present on in_y.
- in_ready  output  1  the block can capture a frame this cycle.
- in_y  input  N_OUT*Y_W  packed frame; y1 in bits [Y_W-1:0], y2 in the next Y_W bits, and so on up to yN_OUT at the MSBs.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  the consumer accepts out_data this cycle.
- out_data  output  Y_W  current word.
- out_index  output  3  index of the current word, 0 = y1.
- out_last  output  1  current word is yN_OUT.
- frame_cnt  output  CNT_W  number of frames fully transmitted, modulo 2^CNT_W.

## Operation
State machine with two states, IDLE and SEND.

IDLE:
- in_ready = 1, out_valid = 0.
- When in_valid = 1, the whole of in_y is registered into the frame buffer, idx is set to 0 and the state moves to SEND.

SEND:
- in_ready = 0.
- out_valid = 1, out_data = buffer word[idx], out_index = idx, out_last = (idx == N_OUT-1).
- A transfer is out_valid && out_ready.
- On a transfer with idx < N_OUT-1: idx increments.
- On a transfer with idx == N_OUT-1: the state returns to IDLE and frame_cnt increments.

Data and handshake rules:
- The buffer is written only on input capture. in_y may change freely after the capture edge.
- While out_valid = 1 and out_ready = 0, out_data, out_index and out_last hold stable.
- out_valid never drops until its word is accepted.
- in_valid while in SEND is ignored; no frame is captured and none is queued. The upstream stage must hold its data until in_ready.
- Words pass through unmodified: no truncation, extension or rounding.
- frame_cnt wraps from 2^CNT_W-1 to 0 with no saturation.
- out_data, out_index and out_last are don't-care in IDLE, but are driven from registers and must not be X after reset.

Reset:
- rst_n = 0 at a rising edge forces IDLE, idx = 0, frame_cnt = 0 and clears the buffer to 0.
- in_ready is gated to 0 while rst_n = 0.
- Reset in the middle of a frame discards the remaining words; no out_last is produced for that frame.

## Timing
- Capture at edge E → out_valid = 1 with y1 in the cycle after E.
- Latency from capture to first word: 1 cycle.
- With out_ready held at 1, the words appear on N_OUT consecutive cycles.
- The last transfer occurs at edge E+N_OUT; IDLE and in_ready = 1 follow in the next cycle.
- Minimum frame period is N_OUT+1 cycles (8 at default), including one capture bubble.
- All outputs are registered or decoded from registered state. There is no combinational path from in_valid or out_ready to any output.
- Reset values:
  - in_ready 0 during reset, 1 in the first cycle after release.
  - out_valid 0, out_data 0, out_index 0, out_last 0, frame_cnt 0.

## Test plan
1. Basic stream: present y1..y7 = 1,2,3,4,5,6,7 with in_valid pulsed for 1 cycle and out_ready = 1.
   - Required: out_data 1..7 on 7 consecutive cycles starting 1 cycle after capture, out_index 0..6, out_last only on value 7.
   - Required: frame_cnt goes 0 → 1, and in_ready returns 1 the cycle after the last transfer.
2. Backpressure: frame 10..16; out_ready = 0 for 3 cycles while out_index = 2, then 1.
   - Required: out_data holds 12 and out_index holds 2 through the stall; no word is dropped or repeated; the total sequence is 10..16.
3. Busy input ignored: while in SEND, drive in_valid = 1 with in_y = all 0xFF.
   - Required: in_ready = 0; the current frame continues unchanged; no 0xFF appears on out_data.
4. Back-to-back frames: in_valid held at 1, in_y changing each capture, out_ready = 1.
   - Required: captures occur every 8 cycles, and each frame streams its own captured values in order.
5. Reset mid-frame: assert rst_n = 0 for 1 cycle while out_index = 3.
   - Required: next cycle out_valid = 0, in_ready = 0 during reset, then 1 after release.
   - Required: frame_cnt unchanged (0); a new frame then streams from y1.
6. Counter wrap: stream 256 complete frames with out_ready = 1.
   - Required: frame_cnt reads 255 after frame 255 and 0 after frame 256.

Source files
------------

// File: rtl/conv_result_serializer_if.sv
// Handshake bundle between the convolution stage, the serializer and its word consumer.
// master = serializer side, slave = the environment driving frames and accepting words.
interface conv_result_serializer_if #(
    parameter int Y_W   = 8,
    parameter int N_OUT = 7,
    parameter int CNT_W = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [N_OUT*Y_W-1:0]   in_y;
    logic                   out_valid;
    logic                   out_ready;
    logic [Y_W-1:0]         out_data;
    logic [2:0]             out_index;
    logic                   out_last;
    logic [CNT_W-1:0]       frame_cnt;

    modport master (
        input  in_valid, in_y, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last, frame_cnt
    );

    modport slave (
        output in_valid, in_y, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last, frame_cnt
    );
endinterface

// File: rtl/conv_result_serializer.sv
// Captures one N_OUT-word convolution result frame and streams it out y1 first.
// Latency: first word valid 1 cycle after capture; min frame period N_OUT+1 cycles.
// Backpressure: out_ready low holds the current word; in_ready low for the whole frame.
module conv_result_serializer #(
    parameter int Y_W   = 8,
    parameter int N_OUT = 7,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    conv_result_serializer_if.master   io
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SEND  = 1'b1;
    localparam logic [2:0] LAST_IDX = 3'(N_OUT - 1);

    logic [0:0]       state;
    logic [2:0]       idx;
    logic [Y_W-1:0]   frame_buf [N_OUT];
    logic [CNT_W-1:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx         <= 3'd0;
            frame_cnt_q <= '0;
            for (int i = 0; i < N_OUT; i++) begin
                frame_buf[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (io.in_valid) begin
                        for (int i = 0; i < N_OUT; i++) begin
                            frame_buf[i] <= io.in_y[i*Y_W +: Y_W];
                        end
                        idx   <= 3'd0;
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // in_valid is deliberately not looked at here: nothing is queued.
                    if (io.out_ready) begin
                        if (idx == LAST_IDX) begin
                            state       <= ST_IDLE;
                            frame_cnt_q <= frame_cnt_q + 1'b1;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode only registered state; rst_n gating keeps in_ready low in reset.
    assign io.in_ready  = (state == ST_IDLE) && rst_n;
    assign io.out_valid = (state == ST_SEND);
    assign io.out_data  = frame_buf[idx];
    assign io.out_index = idx;
    assign io.out_last  = (state == ST_SEND) && (idx == LAST_IDX);
    assign io.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_conv_result_serializer.sv
// Directed bench for conv_result_serializer: stream, stall, busy-ignore, back-to-back,
// mid-frame reset and frame counter wrap, each against hand-computed words.
module tb_conv_result_serializer;
    logic clk = 1'b0;
    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;

    conv_result_serializer_if #(.Y_W(8), .N_OUT(7), .CNT_W(8)) bus ();

    conv_result_serializer #(.Y_W(8), .N_OUT(7), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [55:0] make_frame(input logic [7:0] base);
        logic [55:0] y;
        for (int j = 0; j < 7; j++) y[j*8 +: 8] = base + 8'(j);
        return y;
    endfunction

    function automatic logic [12:0] obs_word();
        return {bus.out_valid, bus.out_index, bus.out_last, bus.out_data};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; bus.in_valid = 1'b0; bus.in_y = '0; bus.out_ready = 1'b0;
        tick(); tick();
        n_total++;
        if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
        else n_pass++;
        n_total++;
        if ({obs_word(), bus.frame_cnt} !== 21'd0)
            $display("FAIL reset_outputs: got %h want 0", {obs_word(), bus.frame_cnt});
        else n_pass++;
        rst_n = 1'b1;
        tick();
        n_total++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_release_in_ready: got %b want 1", bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [12:0] exp;
        bus.in_y = make_frame(8'd1); bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            exp = {1'b1, 3'(k), (k == 6), 8'(1 + k)};
            n_total++;
            if (obs_word() !== exp) $display("FAIL basic_word%0d: got %h want %h", k, obs_word(), exp);
            else n_pass++;
            n_total++;
            if (bus.frame_cnt !== 8'd0) $display("FAIL basic_cnt_mid%0d: got %0d want 0", k, bus.frame_cnt);
            else n_pass++;
            tick();
        end
        n_total++;
        if ({bus.out_valid, bus.in_ready, bus.frame_cnt} !== {1'b0, 1'b1, 8'd1})
            $display("FAIL basic_end: got v=%b rdy=%b cnt=%0d want v=0 rdy=1 cnt=1",
                     bus.out_valid, bus.in_ready, bus.frame_cnt);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [12:0] exp;
        bus.in_y = make_frame(8'd10); bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            exp = {1'b1, 3'(k), (k == 6), 8'(10 + k)};
            n_total++;
            if (obs_word() !== exp) $display("FAIL bp_word%0d: got %h want %h", k, obs_word(), exp);
            else n_pass++;
            if (k == 2) begin
                bus.out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    n_total++;
                    if (obs_word() !== exp) $display("FAIL bp_hold%0d: got %h want %h", s, obs_word(), exp);
                    else n_pass++;
                end
                bus.out_ready = 1'b1;
            end
            tick();
        end
        n_total++;
        if ({bus.out_valid, bus.frame_cnt} !== {1'b0, 8'd2})
            $display("FAIL bp_end: got v=%b cnt=%0d want v=0 cnt=2", bus.out_valid, bus.frame_cnt);
        else n_pass++;
    endtask

    task automatic test_busy_ignored();
        logic [12:0] exp;
        bus.in_y = make_frame(8'd20); bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.in_y = {7{8'hFF}};
        for (int k = 0; k < 7; k++) begin
            exp = {1'b1, 3'(k), (k == 6), 8'(20 + k)};
            n_total++;
            if (obs_word() !== exp) $display("FAIL busy_word%0d: got %h want %h", k, obs_word(), exp);
            else n_pass++;
            n_total++;
            if (bus.in_ready !== 1'b0) $display("FAIL busy_in_ready%0d: got %b want 0", k, bus.in_ready);
            else n_pass++;
            if (k == 6) bus.in_valid = 1'b0;
            tick();
        end
        tick();
        n_total++;
        if ({bus.out_valid, bus.frame_cnt} !== {1'b0, 8'd3})
            $display("FAIL busy_end: got v=%b cnt=%0d want v=0 cnt=3", bus.out_valid, bus.frame_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [12:0] exp;
        bus.out_ready = 1'b1;
        bus.in_y = make_frame(8'h30);
        bus.in_valid = 1'b1;
        for (int f = 0; f < 3; f++) begin
            n_total++;
            if ({bus.in_ready, bus.out_valid} !== 2'b10)
                $display("FAIL b2b_bubble%0d: got rdy=%b v=%b want rdy=1 v=0", f, bus.in_ready, bus.out_valid);
            else n_pass++;
            tick();
            bus.in_y = make_frame(8'(8'h30 + (f + 1) * 16));
            for (int k = 0; k < 7; k++) begin
                exp = {1'b1, 3'(k), (k == 6), 8'(8'h30 + f * 16 + k)};
                n_total++;
                if (obs_word() !== exp) $display("FAIL b2b_f%0d_word%0d: got %h want %h", f, k, obs_word(), exp);
                else n_pass++;
                if (f == 2 && k == 6) bus.in_valid = 1'b0;
                tick();
            end
        end
        n_total++;
        if ({bus.out_valid, bus.frame_cnt} !== {1'b0, 8'd6})
            $display("FAIL b2b_end: got v=%b cnt=%0d want v=0 cnt=6", bus.out_valid, bus.frame_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [12:0] exp;
        bus.in_y = make_frame(8'd40); bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        exp = {1'b1, 3'd3, 1'b0, 8'd43};
        n_total++;
        if (obs_word() !== exp) $display("FAIL rmid_pre: got %h want %h", obs_word(), exp);
        else n_pass++;
        rst_n = 1'b0;
        tick();
        n_total++;
        if ({bus.out_valid, bus.out_last, bus.in_ready} !== 3'b000)
            $display("FAIL rmid_in_reset: got v=%b last=%b rdy=%b want 000",
                     bus.out_valid, bus.out_last, bus.in_ready);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        n_total++;
        if ({bus.in_ready, bus.out_valid, bus.out_data, bus.frame_cnt} !== {1'b1, 1'b0, 8'd0, 8'd0})
            $display("FAIL rmid_release: got rdy=%b v=%b d=%h cnt=%0d want rdy=1 v=0 d=00 cnt=0",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.frame_cnt);
        else n_pass++;
        bus.in_y = make_frame(8'd50); bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            exp = {1'b1, 3'(k), (k == 6), 8'(50 + k)};
            n_total++;
            if (obs_word() !== exp) $display("FAIL rmid_new_word%0d: got %h want %h", k, obs_word(), exp);
            else n_pass++;
            tick();
        end
        n_total++;
        if (bus.frame_cnt !== 8'd1) $display("FAIL rmid_cnt: got %0d want 1", bus.frame_cnt);
        else n_pass++;
    endtask

    task automatic test_counter_wrap();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_total++;
        if (bus.frame_cnt !== 8'd0) $display("FAIL wrap_start: got %0d want 0", bus.frame_cnt);
        else n_pass++;
        bus.in_y = make_frame(8'h80); bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        for (int n = 1; n <= 256; n++) begin
            for (int c = 0; c < 8; c++) tick();
            if (n == 256) bus.in_valid = 1'b0;
            n_total++;
            if (bus.frame_cnt !== 8'(n)) $display("FAIL wrap_frame%0d: got %0d want %0d", n, bus.frame_cnt, 8'(n));
            else n_pass++;
        end
        tick();
        n_total++;
        if ({bus.out_valid, bus.frame_cnt} !== {1'b0, 8'd0})
            $display("FAIL wrap_end: got v=%b cnt=%0d want v=0 cnt=0", bus.out_valid, bus.frame_cnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_busy_ignored();
        test_back_to_back();
        test_reset_mid_frame();
        test_counter_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
